// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: widths, op codes, FSM states.
package muldiv_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;

    // Operation encodings on the op port
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

endpackage

// File: rtl/neg_cond32.sv
// Conditional two's-complement negate, used for operand abs and result sign fix.
module neg_cond32
    import muldiv_pkg::*;
(
    input  logic             neg,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    // Pass through, or return -a when neg is set
    always_comb begin
        y = neg ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Magnitudes are processed radix-2 over 32 cycles, then a FIX cycle applies signs.
module muldiv_hilo
    import muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Read_data1,
    input  logic [WIDTH-1:0] Read_data2,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [5:0] LAST_ITER = 6'(ITER - 1);

    logic [1:0]       state;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] p_hi;      // product high / partial remainder
    logic [WIDTH-1:0] p_lo;      // multiplier bits / dividend-then-quotient
    logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
    logic             fix_mul;   // result in p_hi/p_lo is a product
    logic             res_neg;   // product sign, or quotient sign
    logic             rem_neg;   // remainder takes dividend sign
    logic             dz_pend;   // divide launched with zero divisor

    logic             signed_op;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic             lo_zero;
    logic             fix_hi_neg;
    logic [WIDTH-1:0] lo_fix;
    logic [WIDTH-1:0] hi_neg_out;
    logic [WIDTH-1:0] hi_fix;

    assign busy = (state != ST_IDLE);

    neg_cond32 u_abs_a (
        .neg (signed_op & Read_data1[WIDTH-1]),
        .a   (Read_data1),
        .y   (abs_a)
    );

    neg_cond32 u_abs_b (
        .neg (signed_op & Read_data2[WIDTH-1]),
        .a   (Read_data2),
        .y   (abs_b)
    );

    neg_cond32 u_fix_lo (
        .neg (res_neg),
        .a   (p_lo),
        .y   (lo_fix)
    );

    neg_cond32 u_fix_hi (
        .neg (fix_hi_neg),
        .a   (p_hi),
        .y   (hi_neg_out)
    );

    // One shift-add / restoring-subtract step plus the sign-fix datapath
    always_comb begin
        signed_op = ~op[0];
        mul_sum   = {1'b0, p_hi} + ({(WIDTH+1){p_lo[0]}} & {1'b0, opnd});
        div_shift = {p_hi, p_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ok    = ~div_diff[WIDTH];
        lo_zero   = (p_lo == '0);
        // 64-bit negate: the low word's +1 carries into the high word only when low is zero
        fix_hi_neg = fix_mul ? (res_neg & lo_zero) : rem_neg;
        hi_fix     = (fix_mul & res_neg & ~lo_zero) ? ~p_hi : hi_neg_out;
    end

    // Sequencer, iteration datapath and HI/LO registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            p_hi        <= '0;
            p_lo        <= '0;
            opnd        <= '0;
            fix_mul     <= 1'b0;
            res_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            dz_pend     <= 1'b0;
            HI          <= '0;
            LO          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        fix_mul <= ~op[1];
                        res_neg <= signed_op & (Read_data1[WIDTH-1] ^ Read_data2[WIDTH-1]);
                        rem_neg <= signed_op & op[1] & Read_data1[WIDTH-1];
                        p_hi    <= '0;
                        p_lo    <= op[1] ? abs_a : abs_b;
                        opnd    <= op[1] ? abs_b : abs_a;
                        cnt     <= '0;
                        dz_pend <= op[1] & (Read_data2 == '0);
                        state   <= op[1] ? ST_DIV : ST_MUL;
                    end else begin
                        if (hi_we) HI <= Read_data1;
                        if (lo_we) LO <= Read_data1;
                    end
                end
                ST_MUL: begin
                    p_hi <= mul_sum[WIDTH:1];
                    p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
                    cnt  <= cnt + 6'd1;
                    if (cnt == LAST_ITER) state <= ST_FIX;
                end
                ST_DIV: begin
                    if (dz_pend) begin
                        dz_pend     <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        p_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        p_lo <= {p_lo[WIDTH-2:0], div_ok};
                        cnt  <= cnt + 6'd1;
                        if (cnt == LAST_ITER) state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    HI    <= hi_fix;
                    LO    <= lo_fix;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed vector table, hand-written
// multi-cycle corner sequences and random operations against an arithmetic model.
module tb_muldiv_hilo;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rd1 = '0;
    logic [31:0] rd2 = '0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    muldiv_hilo u_dut (
        .clk         (clk),
        .rst         (rst),
        .Read_data1  (rd1),
        .Read_data2  (rd2),
        .start       (start),
        .op          (op),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .busy        (busy),
        .done        (done),
        .div_by_zero (dbz),
        .HI          (hi),
        .LO          (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: HI/LO as the ISA defines them, via plain 64-bit arithmetic
    task automatic model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            output logic dz);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        case (o)
            OP_MULT: begin
                p = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            OP_DIV: begin
                if (b == 0) dz = 1'b1;
                else begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 0) dz = 1'b1;
                else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
        endcase
    endtask

    // Called at a negedge with the unit idle; returns at the negedge after E0
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int t0);
        op = o;
        rd1 = a;
        rd2 = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
    endtask

    // Returns at the negedge of the done cycle, or after a bounded wait with lat = -1
    task automatic wait_done(input int t0, output int lat, output logic busy_ok,
                             output logic dz_seen);
        lat = -1;
        busy_ok = 1'b1;
        dz_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                lat = cyc - t0;
                dz_seen = dbz;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_done(input string tag, input int lat, input int exp_lat,
                              input logic busy_ok, input logic dz, input logic exp_dz,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " busy_while_running"}, {63'b0, busy_ok}, 64'd1);
        chk({tag, " busy_at_done"}, {63'b0, busy}, 64'd0);
        chk({tag, " div_by_zero"}, {63'b0, dz}, {63'b0, exp_dz});
        chk({tag, " HI"}, {32'b0, hi}, {32'b0, exp_hi});
        chk({tag, " LO"}, {32'b0, lo}, {32'b0, exp_lo});
    endtask

    initial begin
        int t0, lat;
        logic bok, dz, mdz;
        logic [1:0] ro;
        logic [31:0] ra, rb;

        vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 33};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3] = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[5] = '{OP_DIV,   32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        vecs[6] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
        vecs[7] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 33};
        vecs[8] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
        vecs[9] = '{OP_DIV,   32'h00000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFD, 1'b1, 1};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset HI", {32'b0, hi}, 64'd0);
        chk("reset LO", {32'b0, lo}, 64'd0);
        chk("reset busy", {63'b0, busy}, 64'd0);
        chk("reset done", {63'b0, done}, 64'd0);
        chk("reset div_by_zero", {63'b0, dbz}, 64'd0);

        // Directed vector table
        foreach (vecs[i]) begin
            model_op(vecs[i].op, vecs[i].a, vecs[i].b, mdz);
            launch(vecs[i].op, vecs[i].a, vecs[i].b, t0);
            wait_done(t0, lat, bok, dz);
            check_done($sformatf("vec%0d", i), lat, vecs[i].lat, bok, dz, vecs[i].dz,
                       vecs[i].hi, vecs[i].lo);
            @(negedge clk);
        end

        // start again at E5 and hi_we/lo_we while busy are both ignored
        launch(OP_MULT, 32'd7, 32'hFFFFFFFD, t0);
        repeat (4) @(negedge clk);
        op = OP_DIVU;
        rd1 = 32'h0000DEAD;
        rd2 = 32'd5;
        start = 1'b1;
        hi_we = 1'b1;
        lo_we = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wait_done(t0, lat, bok, dz);
        check_done("restart_ignored", lat, 33, bok, dz, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        @(negedge clk);
        chk("restart_ignored no_second_op", {63'b0, busy}, 64'd0);

        // mthi in idle, then mthi+mtlo together
        rd1 = 32'h12345678;
        hi_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi HI", {32'b0, hi}, 64'h12345678);
        chk("mthi LO kept", {32'b0, lo}, 64'hFFFFFFEB);
        rd1 = 32'hCAFEF00D;
        hi_we = 1'b1;
        lo_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("mthi_mtlo HI", {32'b0, hi}, 64'hCAFEF00D);
        chk("mthi_mtlo LO", {32'b0, lo}, 64'hCAFEF00D);

        // start wins over simultaneous writes
        hi_we = 1'b1;
        lo_we = 1'b1;
        launch(OP_MULTU, 32'd3, 32'd5, t0);
        hi_we = 1'b0;
        lo_we = 1'b0;
        wait_done(t0, lat, bok, dz);
        check_done("start_priority", lat, 33, bok, dz, 1'b0, 32'd0, 32'd15);
        @(negedge clk);

        // Asynchronous reset at E10 of a divide
        launch(OP_DIV, 32'd1000, 32'd3, t0);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midop_reset HI", {32'b0, hi}, 64'd0);
        chk("midop_reset LO", {32'b0, lo}, 64'd0);
        chk("midop_reset busy", {63'b0, busy}, 64'd0);
        chk("midop_reset done", {63'b0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        launch(OP_DIV, 32'd100, 32'd7, t0);
        wait_done(t0, lat, bok, dz);
        check_done("after_reset", lat, 33, bok, dz, 1'b0, 32'd2, 32'd14);

        // Overflow divide, then a new start in the done cycle
        @(negedge clk);
        launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF, t0);
        wait_done(t0, lat, bok, dz);
        check_done("ovf_div", lat, 33, bok, dz, 1'b0, 32'h0, 32'h80000000);
        launch(OP_MULTU, 32'h00010000, 32'h00010000, t0);
        wait_done(t0, lat, bok, dz);
        check_done("back_to_back", lat, 33, bok, dz, 1'b0, 32'h1, 32'h0);
        m_hi = 32'h1;
        m_lo = 32'h0;
        @(negedge clk);

        // Random operations against the arithmetic model
        for (int n = 0; n < 30; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
            model_op(ro, ra, rb, mdz);
            launch(ro, ra, rb, t0);
            wait_done(t0, lat, bok, dz);
            check_done($sformatf("rand%0d op%0d %h_%h", n, ro, ra, rb), lat, mdz ? 1 : 33,
                       bok, dz, mdz, m_hi, m_lo);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
